// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : Registered 16-bit ADD/SUB/AND/OR unit with Z/N/C/V status flags;
//            one-cycle latency, a new operation accepted every clock.
// Revision : 1.0 - initial release
// ============================================================================
module alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALU_op,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_AND = 2'b10;
    localparam logic [1:0] c_OP_OR  = 2'b11;
    localparam int         c_MSB    = WIDTH - 1;

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_result_d;
    logic             w_z_d;
    logic             w_n_d;
    logic             w_c_d;
    logic             w_v_d;

    logic [WIDTH-1:0] r_result_q;
    logic             r_z_q;
    logic             r_n_q;
    logic             r_c_q;
    logic             r_v_q;

    // SUB shares the adder as A + ~B + 1, so carry-out doubles as "no borrow"
    // and one overflow rule (equal operand signs, result sign flips) covers both.
    always_comb begin
        w_sub      = (ALU_op == c_OP_SUB);
        w_b_eff    = w_sub ? ~B : B;
        w_sum      = {1'b0, A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
        w_result_d = '0;
        w_c_d      = 1'b0;
        w_v_d      = 1'b0;
        case (ALU_op)
            c_OP_ADD, c_OP_SUB: begin
                w_result_d = w_sum[WIDTH-1:0];
                w_c_d      = w_sum[WIDTH];
                w_v_d      = (A[c_MSB] == w_b_eff[c_MSB]) && (w_sum[c_MSB] != A[c_MSB]);
            end
            c_OP_AND: w_result_d = A & B;
            c_OP_OR:  w_result_d = A | B;
            default:  w_result_d = '0;
        endcase
        w_z_d = (w_result_d == '0);
        w_n_d = w_result_d[c_MSB];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result_q <= '0;
            r_z_q      <= 1'b0;
            r_n_q      <= 1'b0;
            r_c_q      <= 1'b0;
            r_v_q      <= 1'b0;
        end else begin
            r_result_q <= w_result_d;
            r_z_q      <= w_z_d;
            r_n_q      <= w_n_d;
            r_c_q      <= w_c_d;
            r_v_q      <= w_v_d;
        end
    end

    assign result = r_result_q;
    assign Z      = r_z_q;
    assign N      = r_n_q;
    assign C      = r_c_q;
    assign V      = r_v_q;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Purpose  : Self-checking bench for alu: directed literal vectors plus
//            randomized traffic checked every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       ALU_op;
    logic [WIDTH-1:0] result;
    logic             Z, N, C, V;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model outputs: {result, Z, N, C, V}
    logic [WIDTH+3:0] exp_q;

    alu #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .ALU_op (ALU_op),
        .result (result),
        .Z      (Z),
        .N      (N),
        .C      (C),
        .V      (V)
    );

    always #5 clk = ~clk;

    // Plain integer arithmetic: unsigned view for C, signed range test for V.
    function automatic logic [WIDTH+3:0] ref_alu(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0] op);
        longint ua, ub, sa, sb, full, sfull, modv;
        logic [WIDTH-1:0] r;
        logic c, v;
        modv = longint'(1) << WIDTH;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[WIDTH-1] ? ua - modv : ua;
        sb = b[WIDTH-1] ? ub - modv : ub;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            2'b00: begin
                full  = ua + ub;
                sfull = sa + sb;
                r = full[WIDTH-1:0];
                c = (full >= modv);
                v = (sfull >= modv / 2) || (sfull < -(modv / 2));
            end
            2'b01: begin
                full  = ua - ub + modv;
                sfull = sa - sb;
                r = full[WIDTH-1:0];
                c = (ua >= ub);
                v = (sfull >= modv / 2) || (sfull < -(modv / 2));
            end
            2'b10: r = a & b;
            default: r = a | b;
        endcase
        return {r, (r == '0), r[WIDTH-1], c, v};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) exp_q = '0;
        else        exp_q = ref_alu(A, B, ALU_op);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) chk("model_cycle", 32'({result, Z, N, C, V}), 32'(exp_q));
    end

    typedef struct packed {
        logic             rst_n;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       op;
        logic [WIDTH-1:0] r;
        logic [3:0]       znc;
    } vec_t;

    localparam int NV = 13;
    // Hand-computed expectations; flag nibble is {Z, N, C, V}.
    localparam vec_t VECS [NV] = '{
        '{1'b1, 16'h0001, 16'h0001, 2'b00, 16'h0002, 4'b0000},
        '{1'b1, 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 4'b1010},
        '{1'b1, 16'h7FFF, 16'h0001, 2'b00, 16'h8000, 4'b0101},
        '{1'b1, 16'h0002, 16'h0001, 2'b01, 16'h0001, 4'b0010},
        '{1'b1, 16'h0001, 16'h0002, 2'b01, 16'hFFFF, 4'b0100},
        '{1'b1, 16'h8000, 16'h0001, 2'b01, 16'h7FFF, 4'b0011},
        '{1'b1, 16'h00FF, 16'h0F0F, 2'b10, 16'h000F, 4'b0000},
        '{1'b1, 16'h00F0, 16'h0F00, 2'b11, 16'h0FF0, 4'b0000},
        '{1'b1, 16'h00FF, 16'hFF00, 2'b10, 16'h0000, 4'b1000},
        '{1'b0, 16'hFFFF, 16'hFFFF, 2'b00, 16'h0000, 4'b0000},
        '{1'b1, 16'h8000, 16'h0001, 2'b11, 16'h8001, 4'b0100},
        '{1'b1, 16'h0005, 16'h0005, 2'b01, 16'h0000, 4'b1010},
        '{1'b1, 16'h8000, 16'h8000, 2'b00, 16'h0000, 4'b1011}
    };

    function automatic logic [WIDTH-1:0] pick_operand();
        logic [WIDTH-1:0] corner [5];
        corner[0] = 16'h0000;
        corner[1] = 16'h0001;
        corner[2] = 16'h7FFF;
        corner[3] = 16'h8000;
        corner[4] = 16'hFFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return WIDTH'($urandom);
    endfunction

    initial begin
        rst_n  = 1'b0;
        A      = 16'h1234;
        B      = 16'h1111;
        ALU_op = 2'b00;
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_out", 32'({result, Z, N, C, V}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_out", 32'({result, Z, N, C, V}), 32'({16'h2345, 4'b0000}));

        // Back-to-back directed sequence: vector i is checked one edge later.
        for (int i = 0; i <= NV; i++) begin
            if (i > 0) begin
                chk($sformatf("dir%0d_dut", i - 1), 32'({result, Z, N, C, V}),
                    32'({VECS[i-1].r, VECS[i-1].znc}));
                chk($sformatf("dir%0d_model", i - 1), 32'(exp_q),
                    32'({VECS[i-1].r, VECS[i-1].znc}));
            end
            if (i < NV) begin
                rst_n  = VECS[i].rst_n;
                A      = VECS[i].a;
                B      = VECS[i].b;
                ALU_op = VECS[i].op;
                @(negedge clk);
            end
        end

        // Held inputs: outputs must stay put.
        rst_n  = 1'b1;
        A      = 16'h7FFF;
        B      = 16'hFFFF;
        ALU_op = 2'b01;
        repeat (3) @(negedge clk);
        chk("hold_out", 32'({result, Z, N, C, V}), 32'({16'h8000, 4'b0101}));

        for (int k = 0; k < 500; k++) begin
            rst_n  = ($urandom_range(0, 31) != 0);
            A      = pick_operand();
            B      = pick_operand();
            ALU_op = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu.md
Name: alu

Overview:
- Registered 16-bit arithmetic/logic unit for the simple MIPS-style RISC datapath.
- Each clock it computes add, subtract, AND or OR of two operands, selected by a 2-bit opcode.
- Result and status flags (zero, negative, carry, overflow) are captured in output registers one cycle later.
- Flags feed the branch/condition logic; result feeds register write-back.

Parameters:
- WIDTH, 16, operand/result bit width (must be >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALU_op  input  2  operation select.
- result  output  WIDTH  registered operation result.
- Z  output  1  registered zero flag.
- N  output  1  registered negative flag.
- C  output  1  registered carry flag.
- V  output  1  registered signed-overflow flag.

Behaviour:
- Single clock domain; no combinational path from inputs to outputs; all outputs are flops.
- Reset: on a rising clk with rst_n=0, result=0, Z=0, N=0, C=0, V=0. Reset has priority over any operation. Reset asserted mid-stream discards the in-flight computation.
- Latency: 1 cycle. Inputs sampled on rising edge k appear on the outputs after edge k. A new operation is accepted every cycle; there is no handshake or stall.
- Opcodes:
  - 00 ADD: result = (A + B) mod 2^WIDTH.
  - 01 SUB: result = (A - B) mod 2^WIDTH, computed as A + ~B + 1.
  - 10 AND: result = A & B.
  - 11 OR: result = A | B.
- Z = 1 iff the next result equals 0, for all ops.
- N = result[WIDTH-1], for all ops.
- C:
  - ADD: carry out of bit WIDTH-1.
  - SUB: carry out of A + ~B + 1, i.e. 1 when A >= B unsigned (no borrow).
  - AND/OR: 0.
- V:
  - ADD: 1 when A and B have the same sign and the result sign differs.
  - SUB: 1 when A and B have different signs and the result sign differs from A.
  - AND/OR: 0.
- Flags are computed from the same-cycle next-result value, never from the previous registered result.
- Wrap-around: ADD/SUB wrap modulo 2^WIDTH with no saturation. Overflow is reported only via C and V.
- Inputs held constant cause the outputs to hold their values (idempotent recompute every cycle).
- Opcode changes between cycles take effect on the next edge with no pipeline interaction.
- Operands are treated as unsigned for C and as two's-complement for N and V.

Test Plan:
- Reset: rst_n=0 for 2 edges with A=1234, B=1111, ALU_op=00 -> result=0000, Z=0, N=0, C=0, V=0. Release rst_n -> next edge result=2345.
- ADD:
  - 0001+0001 -> 0002, Z0 N0 C0 V0 (one edge later).
  - FFFF+0001 -> 0000, Z1 N0 C1 V0.
  - 7FFF+0001 -> 8000, N1 V1 C0.
- SUB:
  - 0002-0001 -> 0001, Z0 N0 C1 V0.
  - 0001-0002 -> FFFF, N1 C0 V0.
  - 8000-0001 -> 7FFF, V1 C1.
- Logic:
  - AND 00FF&0F0F -> 000F, Z0 N0 C0 V0.
  - OR 00F0|0F00 -> 0FF0.
  - AND 00FF&FF00 -> 0000, Z1.
- Back-to-back: change op/operands every cycle over the sequence above -> each output appears exactly one edge after its inputs, with no dropped or duplicated results. Assert reset mid-sequence -> outputs 0 on that edge; the sequence resumes after release.
